imem_fetch_ctrl: RTL

//  Fetch sequencer that sits in front of the instruction memory. It owns the PC, issues

---
 rtl/imem_fetch_ctrl_if.sv | 45 ++++
 rtl/imem_fetch_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of the IMEM read port, the decode valid/ready handshake and the redirect
// inputs shared by the fetch controller and its environment.
`timescale 1ns/1ps

interface imem_fetch_ctrl_if;
  logic        en;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    input  en,
    input  imem_data,
    input  if_ready,
    input  redirect,
    input  redirect_pc,
    output imem_addr,
    output imem_rd,
    output if_valid,
    output if_instr,
    output if_pc,
    output busy
  );

  modport slave (
    output en,
    output imem_data,
    output if_ready,
    output redirect,
    output redirect_pc,
    input  imem_addr,
    input  imem_rd,
    input  if_valid,
    input  if_instr,
    input  if_pc,
    input  busy
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one IMEM read at a time, waits MEM_LAT cycles
// and presents the word to decode through a single-entry valid/ready buffer.
`timescale 1ns/1ps

module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MEM_LAT  = 1
) (
  input logic              clk,
  input logic              rst,
  imem_fetch_ctrl_if.master fetch_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};
  localparam logic [3:0]  CNT_LOAD   = 4'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        rd_q, rd_d;
  logic        busy_q, busy_d;
  logic        xfer;

  assign xfer = valid_q & fetch_if.if_ready;

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC_W;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      instr_q <= 32'h0000_0000;
      ipc_q   <= 32'h0000_0000;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and datapath update; redirect overrides every state.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;

    if (fetch_if.redirect) begin
      // A redirect in REQ detours via IDLE so the strobe never fires twice in a row.
      pc_d    = word_align(fetch_if.redirect_pc);
      cnt_d   = 4'd0;
      valid_d = 1'b0;
      if (fetch_if.en && (state_q != S_REQ)) begin
        state_d = S_REQ;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_if.en) begin
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_REQ: begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            instr_d = fetch_if.imem_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_HOLD;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (xfer) begin
            valid_d = 1'b0;
            if (fetch_if.en) begin
              state_d = S_REQ;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_HOLD;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    rd_d   = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
  end

  assign fetch_if.imem_addr = pc_q;
  assign fetch_if.imem_rd   = rd_q;
  assign fetch_if.if_valid  = valid_q;
  assign fetch_if.if_instr  = instr_q;
  assign fetch_if.if_pc     = ipc_q;
  assign fetch_if.busy      = busy_q;

endmodule
